// File: rtl/m31_sqr_arbiter.sv
// Round-robin arbiter time-sharing one 4-stage M31 squaring pipeline among N_REQ requesters.
// Define M31_SQR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead.
module m31_sqr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*31-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [N_REQ-1:0]    rsp_valid_o,
    output logic [30:0]         rsp_data_o,
    output logic [2:0]          inflight_o,
    output logic [31:0]         grant_cnt_o
);

    localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LAT   = 4;
    localparam logic [31:0] MODP  = 32'h7FFF_FFFF;

    // Arbitration
    logic             gnt_any;
    logic [TAG_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_vec;

`ifndef M31_SQR_ARB_FIXED_PRIO_EN
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] cand;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
`ifdef M31_SQR_ARB_FIXED_PRIO_EN
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[TAG_W'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_W'(k);
            end
        end
`else
        cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = TAG_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!gnt_any && req_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`endif
        // Ready is forced low while reset is held so nothing is accepted.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = gnt_vec;

`ifndef M31_SQR_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end
`endif

    // Owner tags: one-hot per stage, all-zero for a bubble.
    logic [LAT-1:0][N_REQ-1:0] tag_q, tag_d;
    logic [2:0]                inflight_q, inflight_d;
    logic [31:0]               grant_cnt_q, grant_cnt_d;
    logic [30:0]               rsp_data_q, rsp_data_d;

    // Squaring datapath: multiply, fold, fold, canonicalise.
    logic [30:0] sq_op;
    logic [61:0] op_ext;
    logic [61:0] prod_q, prod_d;
    logic [31:0] fold1_q, fold1_d;
    logic [31:0] fold2_q, fold2_d;
    logic [30:0] canon;

    always_comb begin
        sq_op   = req_data_i[31*32'(gnt_idx) +: 31];
        op_ext  = {31'b0, sq_op};
        prod_d  = op_ext * op_ext;
        fold1_d = {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
        fold2_d = {1'b0, fold1_q[30:0]} + {31'b0, fold1_q[31]};
        // fold2 is at most 2^31, so one conditional subtract makes it canonical.
        canon   = (fold2_q >= MODP) ? 31'(fold2_q - MODP) : fold2_q[30:0];
    end

    always_comb begin
        tag_d       = {tag_q[LAT-2:0], gnt_vec};
        grant_cnt_d = grant_cnt_q + {31'b0, gnt_any};
        rsp_data_d  = (|tag_q[LAT-2]) ? canon : rsp_data_q;
        inflight_d  = '0;
        for (int unsigned s = 0; s < LAT; s++) begin
            inflight_d = inflight_d + {2'b00, |tag_d[s]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q       <= '0;
            inflight_q  <= '0;
            grant_cnt_q <= '0;
            rsp_data_q  <= '0;
`ifndef M31_SQR_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            grant_cnt_q <= grant_cnt_d;
            rsp_data_q  <= rsp_data_d;
`ifndef M31_SQR_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Data stages carry no control meaning; stale values are masked by the tags.
    always_ff @(posedge clk) begin
        prod_q  <= prod_d;
        fold1_q <= fold1_d;
        fold2_q <= fold2_d;
    end

    assign rsp_valid_o = tag_q[LAT-1];
    assign rsp_data_o  = rsp_data_q;
    assign inflight_o  = inflight_q;
    assign grant_cnt_o = grant_cnt_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready_o));
    a_rsp_onehot:   assert property (@(posedge clk) $onehot0(rsp_valid_o));
    a_inflight_max: assert property (@(posedge clk) inflight_o <= 3'(LAT));

endmodule

// File: tb/tb_m31_sqr_arbiter.sv
// Bench for m31_sqr_arbiter: constant vector table, hand-written corner sequences, and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_m31_sqr_arbiter;

    localparam int N = 4;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*31-1:0]   req_data_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      rsp_valid_o;
    logic [30:0]       rsp_data_o;
    logic [2:0]        inflight_o;
    logic [31:0]       grant_cnt_o;

    m31_sqr_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .inflight_o  (inflight_o),
        .grant_cnt_o (grant_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int own; logic [30:0] val; } op_t;
    typedef struct { int cyc; logic [N-1:0] v; logic [30:0] d; } obs_t;
    typedef struct { logic [30:0] op; logic [30:0] sq; } vec_t;

    op_t          mq[$];
    obs_t         obs[$];
    int           gnt_log[$];
    int           cyc = 0;
    int           ptr = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           max_infl = 0;
    longint       mcnt = 0;
    logic [30:0]  m_data = '0;
    logic [N-1:0] last_rdy;

    function automatic logic [30:0] ref_sq(input logic [30:0] a);
        longint unsigned x;
        x = 64'(a);
        return 31'((x * x) % P);
    endfunction

    function automatic logic [N*31-1:0] lane(input int i, input logic [30:0] v);
        logic [N*31-1:0] r;
        r = '0;
        r[31*i +: 31] = v;
        return r;
    endfunction

    function automatic logic [30:0] rand_op();
        return ($urandom_range(0, 7) == 0) ? 31'h7FFF_FFFF : 31'($urandom);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check arbitration, step the model, check registered outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N*31-1:0] d, input logic rst);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_v;
        logic [30:0]  a;
        int           g;
        int           fired;
        op_t          op;
        obs_t         ob;
        rst_n       = ~rst;
        req_valid_i = v;
        req_data_i  = d;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready_o;
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        for (int k = 0; k < N; k++) begin
            if (req_ready_o[k]) gnt_log.push_back(k);
        end
        if (g >= 0) begin
            a = d[31*g +: 31];
            op.due = cyc + 4;
            op.own = g;
            op.val = ref_sq(a);
            mq.push_back(op);
            mcnt++;
`ifndef M31_SQR_ARB_FIXED_PRIO_EN
            ptr = (g + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
            mcnt   = 0;
            ptr    = 0;
            m_data = '0;
        end
        exp_v = '0;
        fired = 0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            exp_v[mq[0].own] = 1'b1;
            m_data = mq[0].val;
            mq.delete(0);
            fired = 1;
        end
        chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
        chk("rsp_data", 64'(rsp_data_o), 64'(m_data));
        chk("inflight", 64'(inflight_o), 64'(mq.size() + fired));
        chk("grant_cnt", 64'(grant_cnt_o), 64'(mcnt[31:0]));
        if (int'(inflight_o) > max_infl) max_infl = int'(inflight_o);
        if (rsp_valid_o != '0) begin
            ob.cyc = cyc;
            ob.v   = rsp_valid_o;
            ob.d   = rsp_data_o;
            obs.push_back(ob);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
    endtask

    initial begin
        vec_t tbl[5];
        logic [N*31-1:0] d;
        int exp_own;
        logic [N-1:0] exp_pair;

        tbl[0] = '{op: 31'h7FFF_FFFE, sq: 31'h0000_0001};
        tbl[1] = '{op: 31'h0001_0000, sq: 31'h0000_0002};
        tbl[2] = '{op: 31'h4000_0000, sq: 31'h2000_0000};
        tbl[3] = '{op: 31'h7FFF_FFFF, sq: 31'h0000_0000};
        tbl[4] = '{op: 31'h0000_0000, sq: 31'h0000_0000};

        // Reset state
        cycle('0, '0, 1'b1);
        cycle('1, '1, 1'b1);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("reset_inflight", 64'(inflight_o), 64'd0);
        chk("reset_grant_cnt", 64'(grant_cnt_o), 64'd0);

        // Single op: 3 -> 9 four cycles after acceptance
        cycle(4'b0001, lane(0, 31'd3), 1'b0);
        chk("single_inflight_first", 64'(inflight_o), 64'd1);
        for (int j = 1; j <= 3; j++) begin
            idle(1);
            chk("single_inflight", 64'(inflight_o), 64'd1);
            chk("single_rsp_valid", 64'(rsp_valid_o), (j == 3) ? 64'd1 : 64'd0);
        end
        chk("single_rsp_data", 64'(rsp_data_o), 64'd9);
        idle(1);
        chk("single_drained", 64'(inflight_o), 64'd0);
        chk("single_data_hold", 64'(rsp_data_o), 64'd9);

        // Edge-value table from requester 1, back to back
        obs.delete();
        foreach (tbl[i]) cycle(4'b0010, lane(1, tbl[i].op), 1'b0);
        idle(5);
        chk("edge_count", 64'(obs.size()), 64'd5);
        if (obs.size() == 5) begin
            foreach (tbl[i]) begin
                chk("edge_owner", 64'(obs[i].v), 64'(4'b0010));
                chk("edge_value", 64'(obs[i].d), 64'(tbl[i].sq));
                chk("edge_spacing", 64'(obs[i].cyc - obs[0].cyc), 64'(i));
            end
        end

        // Contention: all valid for 8 cycles straight from reset
        cycle('0, '0, 1'b1);
        gnt_log.delete();
        obs.delete();
        max_infl = 0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) d[31*k +: 31] = rand_op();
            cycle('1, d, 1'b0);
        end
        chk("contend_grant_cnt", 64'(grant_cnt_o), 64'd8);
        chk("contend_inflight_max", 64'(max_infl), 64'd4);
        idle(5);
        chk("contend_grants", 64'(gnt_log.size()), 64'd8);
        chk("contend_rsps", 64'(obs.size()), 64'd8);
        if (gnt_log.size() == 8 && obs.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
`ifdef M31_SQR_ARB_FIXED_PRIO_EN
                exp_own = 0;
`else
                exp_own = i % N;
`endif
                chk("contend_grant_order", 64'(gnt_log[i]), 64'(exp_own));
                chk("contend_rsp_order", 64'(obs[i].v), 64'(1 << exp_own));
            end
        end

        // Reset while three ops are in flight
        obs.delete();
        for (int i = 0; i < 3; i++) cycle(4'b0001, lane(0, rand_op()), 1'b0);
        cycle(4'b0001, lane(0, 31'd7), 1'b1);
        chk("midrst_ready_low", 64'(last_rdy), 64'd0);
        chk("midrst_inflight", 64'(inflight_o), 64'd0);
        chk("midrst_grant_cnt", 64'(grant_cnt_o), 64'd0);
        idle(6);
        chk("midrst_no_rsp", 64'(obs.size()), 64'd0);
        cycle(4'b0001, lane(0, 31'd5), 1'b0);
        idle(3);
        chk("midrst_next_valid", 64'(rsp_valid_o), 64'd1);
        chk("midrst_next_data", 64'(rsp_data_o), 64'd25);

        // Sparse traffic from requester 2, then a tie between 1 and 3
        obs.delete();
        for (int r = 0; r < 6; r++) begin
            cycle(4'b0100, lane(2, rand_op()), 1'b0);
            idle(2);
        end
        idle(4);
        chk("sparse_rsps", 64'(obs.size()), 64'd6);
        cycle(4'b1010, lane(1, 31'd11) | lane(3, 31'd13), 1'b0);
`ifdef M31_SQR_ARB_FIXED_PRIO_EN
        exp_pair = 4'b0010;
`else
        exp_pair = 4'b1000;
`endif
        chk("sparse_ptr_after_2", 64'(last_rdy), 64'(exp_pair));
        idle(5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) d[31*k +: 31] = rand_op();
            cycle(4'($urandom), d, $urandom_range(0, 63) == 0);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
